// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : l2_arbiter
//  Description : Shares one L2 cache between the L1 I-cache and L1 D-cache.
//                It grants one line request at a time and latches the granted
//                address, write line and op. It drives the L2 read/write
//                strobes until l2_resp, then returns the response only to the
//                granted port. A one-cycle RELEASE state follows every
//                response.
//  Ports       : clk, rst                  clock, synchronous active-high reset
//                i_read, i_addr            I-cache read request (held to resp)
//                i_rdata, i_resp           I-cache return line / done pulse
//                d_read, d_write, d_addr,  D-cache read / writeback request
//                d_wdata                   (held to resp)
//                d_rdata, d_resp           D-cache return line / done pulse
//                l2_read, l2_write,        L2 strobes and latched request
//                l2_addr, l2_wdata
//                l2_rdata, l2_resp         L2 return line / completion
//  Options     : L2_ARB_ROUND_ROBIN_EN     alternate grants on ties. When it is
//                                          not defined, the D port wins ties.
//  Revision    : 1.0  initial release
// ============================================================================
module l2_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SERVE_I = 2'd1;
    localparam logic [1:0] c_ST_SERVE_D = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_is_write;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
    localparam logic c_GRANT_I = 1'b0;
    localparam logic c_GRANT_D = 1'b1;

    logic r_last_grant;

    // On a tie, the port that lost the previous grant wins.
    assign w_grant_i = (r_state == c_ST_IDLE) && w_i_req &&
                       (!w_d_req || (r_last_grant == c_GRANT_D));

    // Reset to D so that the I port wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= c_GRANT_D;
        end else if (w_grant_i) begin
            r_last_grant <= c_GRANT_I;
        end else if (w_grant_d) begin
            r_last_grant <= c_GRANT_D;
        end
    end
`else
    // Fixed priority: I is granted only when D is not requesting.
    assign w_grant_i = (r_state == c_ST_IDLE) && w_i_req && !w_d_req;
`endif

    assign w_grant_d = (r_state == c_ST_IDLE) && w_d_req && !w_grant_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        l2_read     = 1'b0;
        l2_write    = 1'b0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_i) begin
                    w_state_nxt = c_ST_SERVE_I;
                end else if (w_grant_d) begin
                    w_state_nxt = c_ST_SERVE_D;
                end
            end
            c_ST_SERVE_I: begin
                l2_read  = ~r_is_write;
                l2_write = r_is_write;
                if (l2_resp) begin
                    i_resp      = 1'b1;
                    w_state_nxt = c_ST_RELEASE;
                end
            end
            c_ST_SERVE_D: begin
                l2_read  = ~r_is_write;
                l2_write = r_is_write;
                if (l2_resp) begin
                    d_resp      = 1'b1;
                    w_state_nxt = c_ST_RELEASE;
                end
            end
            default: begin
                // RELEASE: one quiet cycle so the L1 can drop its request.
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Request latch, loaded only on a grant. An I read leaves the write
    // line untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
        end else if (w_grant_i) begin
            r_addr     <= i_addr;
            r_is_write <= 1'b0;
        end else if (w_grant_d) begin
            r_addr     <= d_addr;
            r_wdata    <= d_wdata;
            r_is_write <= d_write;   // write wins over a simultaneous read
        end
    end

    assign l2_addr  = r_addr;
    assign l2_wdata = r_wdata;
    assign i_rdata  = l2_rdata;
    assign d_rdata  = l2_rdata;

endmodule
`default_nettype wire

// File: tb/tb_l2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_arbiter
//  Description : Directed self-checking bench for l2_arbiter. Each scenario
//                task drives its own stimulus and checks the results inline.
//                Tie-break expectations follow L2_ARB_ROUND_ROBIN_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_l2_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    // Inputs change 1 ns after a rising edge. Outputs are sampled on the
    // falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        l2_resp = 1'b0;
    endtask

    // Called in a serve cycle with l2_resp already high. Leaves the bench
    // one cycle into IDLE with all requests dropped.
    task automatic finish_idle();
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        idle_inputs();
        i_addr   = '0;
        d_addr   = '0;
        d_wdata  = '0;
        l2_rdata = '0;
        cyc();
        cyc();
        settle();
        n_checks++; if (l2_read !== 1'b0) $display("FAIL reset_l2_read: got %0b want 0", l2_read); else n_pass++;
        n_checks++; if (l2_write !== 1'b0) $display("FAIL reset_l2_write: got %0b want 0", l2_write); else n_pass++;
        n_checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) $display("FAIL reset_resp: got i=%0b d=%0b want 0 0", i_resp, d_resp); else n_pass++;
        n_checks++; if (l2_addr !== '0) $display("FAIL reset_addr: got %h want 0", l2_addr); else n_pass++;
        n_checks++; if (l2_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", l2_wdata); else n_pass++;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_lone_i();
        logic [LINE_W-1:0] pat;
        pat = {8{32'hDEAD_BEEF}};
        // cycle 0
        i_read = 1'b1;
        i_addr = 32'h0000_1040;
        settle();
        n_checks++; if (l2_read !== 1'b0) $display("FAIL lone_i_c0: l2_read=%0b want 0", l2_read); else n_pass++;
        cyc(); settle();  // cycle 1
        n_checks++; if (l2_read !== 1'b1 || l2_write !== 1'b0) $display("FAIL lone_i_strobe: rd=%0b wr=%0b want 1 0", l2_read, l2_write); else n_pass++;
        n_checks++; if (l2_addr !== 32'h0000_1040) $display("FAIL lone_i_addr: got %h want 00001040", l2_addr); else n_pass++;
        for (int c = 2; c <= 4; c++) begin
            cyc(); settle();
            n_checks++; if (l2_read !== 1'b1 || i_resp !== 1'b0) $display("FAIL lone_i_hold c%0d: rd=%0b resp=%0b want 1 0", c, l2_read, i_resp); else n_pass++;
        end
        cyc();  // cycle 5
        l2_resp  = 1'b1;
        l2_rdata = pat;
        settle();
        n_checks++; if (i_resp !== 1'b1 || d_resp !== 1'b0) $display("FAIL lone_i_resp: i=%0b d=%0b want 1 0", i_resp, d_resp); else n_pass++;
        n_checks++; if (i_rdata !== pat) $display("FAIL lone_i_rdata: got %h want %h", i_rdata, pat); else n_pass++;
        cyc();  // cycle 6: RELEASE
        l2_resp = 1'b0;
        i_read  = 1'b0;
        settle();
        n_checks++; if (l2_read !== 1'b0 || i_resp !== 1'b0) $display("FAIL lone_i_release: rd=%0b resp=%0b want 0 0", l2_read, i_resp); else n_pass++;
        cyc();  // cycle 7: IDLE, a new request is sampled here
        i_read = 1'b1;
        i_addr = 32'h0000_2000;
        settle();
        n_checks++; if (l2_read !== 1'b0) $display("FAIL lone_i_idle7: rd=%0b want 0", l2_read); else n_pass++;
        cyc();  // cycle 8
        l2_resp = 1'b1;
        settle();
        n_checks++; if (l2_read !== 1'b1 || l2_addr !== 32'h0000_2000) $display("FAIL lone_i_regrant: rd=%0b addr=%h want 1 00002000", l2_read, l2_addr); else n_pass++;
        finish_idle();
    endtask

    task automatic test_d_write();
        logic [LINE_W-1:0] a5;
        a5 = {32{8'hA5}};
        d_write = 1'b1;
        d_addr  = 32'h8000_0020;
        d_wdata = a5;
        cyc(); settle();
        n_checks++; if (l2_write !== 1'b1 || l2_read !== 1'b0) $display("FAIL dwr_strobe: wr=%0b rd=%0b want 1 0", l2_write, l2_read); else n_pass++;
        n_checks++; if (l2_wdata !== a5) $display("FAIL dwr_wdata: got %h want %h", l2_wdata, a5); else n_pass++;
        n_checks++; if (l2_addr !== 32'h8000_0020) $display("FAIL dwr_addr: got %h want 80000020", l2_addr); else n_pass++;
        cyc(); settle();
        n_checks++; if (l2_write !== 1'b1 || d_resp !== 1'b0) $display("FAIL dwr_hold: wr=%0b resp=%0b want 1 0", l2_write, d_resp); else n_pass++;
        cyc();
        l2_resp = 1'b1;
        settle();
        n_checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0) $display("FAIL dwr_resp: d=%0b i=%0b want 1 0", d_resp, i_resp); else n_pass++;
        cyc();
        l2_resp = 1'b0;
        d_write = 1'b0;
        settle();
        n_checks++; if (d_resp !== 1'b0 || l2_write !== 1'b0) $display("FAIL dwr_pulse: resp=%0b wr=%0b want 0 0", d_resp, l2_write); else n_pass++;
        cyc();
    endtask

    task automatic test_write_wins();
        logic [LINE_W-1:0] pat;
        pat = {8{32'h0BAD_F00D}};
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h0000_0040;
        d_wdata = {32{8'h3C}};
        cyc();
        l2_resp  = 1'b1;
        l2_rdata = pat;
        settle();
        n_checks++; if (l2_write !== 1'b1 || l2_read !== 1'b0) $display("FAIL write_wins: wr=%0b rd=%0b want 1 0", l2_write, l2_read); else n_pass++;
        n_checks++; if (d_resp !== 1'b1 || d_rdata !== pat) $display("FAIL write_wins_resp: resp=%0b rdata=%h want 1 %h", d_resp, d_rdata, pat); else n_pass++;
        finish_idle();
    endtask

    task automatic test_tie();
        logic exp_first_i;
        logic [ADDR_W-1:0] a_first;
        logic [ADDR_W-1:0] a_second;
`ifdef L2_ARB_ROUND_ROBIN_EN
        exp_first_i = 1'b1;
`else
        exp_first_i = 1'b0;
`endif
        a_first  = exp_first_i ? 32'h0000_1000 : 32'h0000_2000;
        a_second = exp_first_i ? 32'h0000_2000 : 32'h0000_1000;
        apply_reset();
        i_read = 1'b1; i_addr = 32'h0000_1000;
        d_read = 1'b1; d_addr = 32'h0000_2000;
        cyc();  // cycle 1: first grant served, respond at once
        l2_resp = 1'b1;
        settle();
        n_checks++; if (l2_addr !== a_first || l2_read !== 1'b1) $display("FAIL tie_first: addr=%h rd=%0b want %h 1", l2_addr, l2_read, a_first); else n_pass++;
        n_checks++; if (i_resp !== exp_first_i || d_resp !== !exp_first_i) $display("FAIL tie_first_resp: i=%0b d=%0b want %0b %0b", i_resp, d_resp, exp_first_i, !exp_first_i); else n_pass++;
        cyc();  // cycle 2: RELEASE, winner drops its request
        l2_resp = 1'b0;
        if (exp_first_i) i_read = 1'b0; else d_read = 1'b0;
        settle();
        n_checks++; if (l2_read !== 1'b0) $display("FAIL tie_release: rd=%0b want 0", l2_read); else n_pass++;
        cyc(); settle();  // cycle 3: IDLE samples the waiting port
        n_checks++; if (l2_read !== 1'b0) $display("FAIL tie_idle: rd=%0b want 0", l2_read); else n_pass++;
        cyc();  // cycle 4: second grant
        l2_resp = 1'b1;
        settle();
        n_checks++; if (l2_addr !== a_second || l2_read !== 1'b1) $display("FAIL tie_second: addr=%h rd=%0b want %h 1", l2_addr, l2_read, a_second); else n_pass++;
        n_checks++; if (i_resp !== !exp_first_i || d_resp !== exp_first_i) $display("FAIL tie_second_resp: i=%0b d=%0b want %0b %0b", i_resp, d_resp, !exp_first_i, exp_first_i); else n_pass++;
        finish_idle();
    endtask

    task automatic test_round_robin();
        logic exp_i;
        apply_reset();
        i_read = 1'b1; i_addr = 32'h0000_0A00;
        d_read = 1'b1; d_addr = 32'h0000_0B00;
        for (int k = 0; k < 4; k++) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
            exp_i = ((k % 2) == 0);
`else
            exp_i = 1'b0;
`endif
            cyc();
            l2_resp = 1'b1;
            settle();
            n_checks++; if (i_resp !== exp_i || d_resp !== !exp_i) $display("FAIL rr_grant k%0d: i=%0b d=%0b want %0b %0b", k, i_resp, d_resp, exp_i, !exp_i); else n_pass++;
            n_checks++; if (l2_addr !== (exp_i ? 32'h0000_0A00 : 32'h0000_0B00)) $display("FAIL rr_addr k%0d: got %h", k, l2_addr); else n_pass++;
            cyc();
            l2_resp = 1'b0;
            cyc();
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_change_during_service();
        d_read = 1'b1;
        d_addr = 32'h0000_0100;
        cyc(); settle();
        n_checks++; if (l2_addr !== 32'h0000_0100 || l2_read !== 1'b1) $display("FAIL chg_start: addr=%h rd=%0b want 00000100 1", l2_addr, l2_read); else n_pass++;
        d_addr = 32'h0000_0200;
        i_read = 1'b1;
        i_addr = 32'h0000_0300;
        cyc(); settle();
        n_checks++; if (l2_addr !== 32'h0000_0100) $display("FAIL chg_addr_held: got %h want 00000100", l2_addr); else n_pass++;
        cyc();
        l2_resp = 1'b1;
        settle();
        n_checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0) $display("FAIL chg_resp: d=%0b i=%0b want 1 0", d_resp, i_resp); else n_pass++;
        cyc();  // RELEASE, with a stray l2_resp that must be ignored
        d_read = 1'b0;
        settle();
        n_checks++; if (d_resp !== 1'b0 || i_resp !== 1'b0) $display("FAIL release_spurious: d=%0b i=%0b want 0 0", d_resp, i_resp); else n_pass++;
        cyc();  // IDLE: the waiting I request is sampled
        l2_resp = 1'b0;
        settle();
        n_checks++; if (l2_read !== 1'b0) $display("FAIL chg_idle: rd=%0b want 0", l2_read); else n_pass++;
        cyc();
        l2_resp = 1'b1;
        settle();
        n_checks++; if (l2_addr !== 32'h0000_0300 || i_resp !== 1'b1) $display("FAIL chg_waiter: addr=%h resp=%0b want 00000300 1", l2_addr, i_resp); else n_pass++;
        finish_idle();
        // Stray l2_resp in IDLE
        l2_resp = 1'b1;
        settle();
        n_checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) $display("FAIL idle_spurious: i=%0b d=%0b want 0 0", i_resp, d_resp); else n_pass++;
        cyc(); settle();
        n_checks++; if (l2_read !== 1'b0 || l2_write !== 1'b0) $display("FAIL idle_spurious_state: rd=%0b wr=%0b want 0 0", l2_read, l2_write); else n_pass++;
        l2_resp = 1'b0;
        d_read  = 1'b1;
        d_addr  = 32'h0000_0500;
        cyc();
        l2_resp = 1'b1;
        settle();
        n_checks++; if (l2_read !== 1'b1 || l2_addr !== 32'h0000_0500) $display("FAIL idle_after_spurious: rd=%0b addr=%h want 1 00000500", l2_read, l2_addr); else n_pass++;
        finish_idle();
    endtask

    task automatic test_reset_mid();
        i_read = 1'b1;
        i_addr = 32'h0000_4440;
        cyc(); settle();
        n_checks++; if (l2_read !== 1'b1) $display("FAIL rstmid_serving: rd=%0b want 1", l2_read); else n_pass++;
        rst = 1'b1;
        cyc();
        rst     = 1'b0;
        l2_resp = 1'b1;
        i_addr  = 32'h0000_5550;
        settle();
        n_checks++; if (l2_read !== 1'b0 || i_resp !== 1'b0) $display("FAIL rstmid_idle: rd=%0b resp=%0b want 0 0", l2_read, i_resp); else n_pass++;
        n_checks++; if (l2_addr !== '0) $display("FAIL rstmid_addr: got %h want 0", l2_addr); else n_pass++;
        cyc();
        l2_resp = 1'b0;
        settle();
        n_checks++; if (l2_read !== 1'b1 || l2_addr !== 32'h0000_5550) $display("FAIL rstmid_regrant: rd=%0b addr=%h want 1 00005550", l2_read, l2_addr); else n_pass++;
        cyc();
        l2_resp = 1'b1;
        settle();
        n_checks++; if (i_resp !== 1'b1) $display("FAIL rstmid_resp: resp=%0b want 1", i_resp); else n_pass++;
        finish_idle();
    endtask

    initial begin
        test_reset();
        test_lone_i();
        test_d_write();
        test_write_wins();
        test_tie();
        test_round_robin();
        test_change_during_service();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
